// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers requests onto the ALU inputs, captures the
// ALU result one cycle later into a small FIFO and retires it downstream.
module alu_issue_ctrl #(
  parameter int          ALU_WIDTH  = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [3:0]  OP_DIV     = 4'd9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALU_WIDTH-1:0]   in_a,
  input  logic [ALU_WIDTH-1:0]   in_b,
  input  logic [3:0]             in_opcode,
  output logic [ALU_WIDTH-1:0]   alu_a,
  output logic [ALU_WIDTH-1:0]   alu_b,
  output logic [3:0]             alu_opcode,
  input  logic [2*ALU_WIDTH-1:0] alu_result,
  input  logic                   alu_a_greater,
  input  logic                   alu_a_equal,
  input  logic                   alu_a_less,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*ALU_WIDTH-1:0] out_result,
  output logic                   out_gt,
  output logic                   out_eq,
  output logic                   out_lt,
  output logic [3:0]             out_opcode,
  output logic                   out_div_zero,
  output logic [15:0]            op_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * ALU_WIDTH;
  localparam int EW = RW + 8;

  logic [ALU_WIDTH-1:0] r_alu_a;
  logic [ALU_WIDTH-1:0] r_alu_b;
  logic [3:0]           r_alu_opcode;
  logic                 r_s1_valid;
  logic [AW-1:0]        r_wp;
  logic [AW-1:0]        r_rp;
  logic [CW-1:0]        r_cnt;
  logic [15:0]          r_op_count;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_div_zero;
  logic [CW:0]   w_occ;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  // Occupancy counts the in-flight issue slot so a capture always fits.
  assign w_occ      = {1'b0, r_cnt} + {{CW{1'b0}}, r_s1_valid};
  assign in_ready   = w_occ < (CW+1)'(FIFO_DEPTH);
  assign w_accept   = in_valid && in_ready;
  assign w_push     = r_s1_valid;
  assign out_valid  = (r_cnt != '0);
  assign w_pop      = out_valid && out_ready;
  assign w_div_zero = (r_alu_opcode == OP_DIV) && (r_alu_b == '0);
  assign w_entry    = {alu_result, alu_a_greater, alu_a_equal,
                       alu_a_less, r_alu_opcode, w_div_zero};
  assign w_head     = out_valid ? r_mem[r_rp] : '0;

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign op_count   = r_op_count;

  assign {out_result, out_gt, out_eq, out_lt,
          out_opcode, out_div_zero} = w_head;

  // Issue stage: load ALU operands on accept, otherwise hold them quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_s1_valid   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_alu_a      <= in_a;
        r_alu_b      <= in_b;
        r_alu_opcode <= in_opcode;
      end
    end
  end

  // FIFO storage: written one cycle after issue with the ALU outputs.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_entry;
  end

  // FIFO pointers, occupancy and the retired-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) begin
        r_rp       <= r_rp + AW'(1);
        r_op_count <= r_op_count + 16'd1;
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of the issue/retire wrapper around
// a small behavioural ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [3:0]  in_opcode = '0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_a_greater;
  logic        alu_a_equal;
  logic        alu_a_less;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_gt;
  logic        out_eq;
  logic        out_lt;
  logic [3:0]  out_opcode;
  logic        out_div_zero;
  logic [15:0] op_count;

  int pass = 0;
  int total = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .alu_a_greater(alu_a_greater),
    .alu_a_equal(alu_a_equal),
    .alu_a_less(alu_a_less),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result),
    .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt),
    .out_opcode(out_opcode), .out_div_zero(out_div_zero),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(
    input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return {8'd0, a} + {8'd0, b};
      4'd1:    return {8'd0, a} - {8'd0, b};
      4'd8:    return {8'd0, a} * {8'd0, b};
      4'd9:    return (b == 0) ? 16'hFFFF : {8'd0, a / b};
      default: return {8'd0, a ^ b};
    endcase
  endfunction

  assign alu_result    = alu_f(alu_a, alu_b, alu_opcode);
  assign alu_a_greater = alu_a > alu_b;
  assign alu_a_equal   = alu_a == alu_b;
  assign alu_a_less    = alu_a < alu_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0d exp 0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0d exp 1", in_ready); else pass++;
    total++; if (op_count !== 16'd0) $display("FAIL rst_op_count got %0d exp 0", op_count); else pass++;
    total++; if (alu_a !== 8'd0 || alu_b !== 8'd0 || alu_opcode !== 4'd0)
      $display("FAIL rst_alu got %0d/%0d/%0d exp 0", alu_a, alu_b, alu_opcode); else pass++;
    total++; if (out_result !== 16'd0) $display("FAIL rst_out_result got %0d exp 0", out_result); else pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd200; in_b = 8'd100; in_opcode = 4'd0;
    tick();
    in_valid = 1'b0;
    total++; if (alu_a !== 8'd200 || alu_b !== 8'd100) $display("FAIL single_alu_in got %0d/%0d exp 200/100", alu_a, alu_b); else pass++;
    total++; if (out_valid !== 1'b0) $display("FAIL single_early got %0d exp 0", out_valid); else pass++;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0d exp 1", out_valid); else pass++;
    total++; if (out_result !== 16'd300) $display("FAIL single_result got %0d exp 300", out_result); else pass++;
    total++; if ({out_gt, out_eq, out_lt} !== 3'b100) $display("FAIL single_flags got %b exp 100", {out_gt, out_eq, out_lt}); else pass++;
    total++; if (out_opcode !== 4'd0 || out_div_zero !== 1'b0) $display("FAIL single_op got %0d/%0d exp 0/0", out_opcode, out_div_zero); else pass++;
    tick();
    total++; if (op_count !== 16'd1) $display("FAIL single_op_count got %0d exp 1", op_count); else pass++;
    total++; if (out_valid !== 1'b0) $display("FAIL single_empty got %0d exp 0", out_valid); else pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5; in_opcode = 4'd1;
    tick();
    total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got %0d exp 1", in_ready); else pass++;
    in_a = 8'd3; in_b = 8'd9; in_opcode = 4'd8;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_result !== 16'd0 || out_eq !== 1'b1 || out_opcode !== 4'd1)
      $display("FAIL b2b_first got v=%0d r=%0d eq=%0d op=%0d exp 1/0/1/1", out_valid, out_result, out_eq, out_opcode); else pass++;
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 16'd27 || out_lt !== 1'b1 || out_opcode !== 4'd8)
      $display("FAIL b2b_second got v=%0d r=%0d lt=%0d op=%0d exp 1/27/1/8", out_valid, out_result, out_lt, out_opcode); else pass++;
    tick();
    total++; if (out_valid !== 1'b0 || op_count !== 16'd3) $display("FAIL b2b_done got v=%0d cnt=%0d exp 0/3", out_valid, op_count); else pass++;
  endtask

  task automatic test_divide();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd42; in_b = 8'd0; in_opcode = 4'd9;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_div_zero !== 1'b1 || out_opcode !== 4'd9)
      $display("FAIL div0_flag got v=%0d dz=%0d op=%0d exp 1/1/9", out_valid, out_div_zero, out_opcode); else pass++;
    total++; if (out_result !== 16'hFFFF) $display("FAIL div0_result got %0h exp ffff", out_result); else pass++;
    tick();
    in_valid = 1'b1; in_b = 8'd6;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_div_zero !== 1'b0 || out_result !== 16'd7)
      $display("FAIL div_ok got v=%0d dz=%0d r=%0d exp 1/0/7", out_valid, out_div_zero, out_result); else pass++;
    tick();
    total++; if (op_count !== 16'd5) $display("FAIL div_op_count got %0d exp 5", op_count); else pass++;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic took;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd10; in_b = 8'd1; in_opcode = 4'd0;
    for (int i = 0; i < 8; i++) begin
      took = in_valid && in_ready;
      if (took) acc++;
      tick();
      if (took) in_a = in_a + 8'd1;
    end
    total++; if (acc !== 4) $display("FAIL bp_accepts got %0d exp 4", acc); else pass++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %0d exp 0", in_ready); else pass++;
    total++; if (out_valid !== 1'b1 || out_result !== 16'd11) $display("FAIL bp_head got v=%0d r=%0d exp 1/11", out_valid, out_result); else pass++;
    tick();
    total++; if (out_result !== 16'd11 || out_opcode !== 4'd0) $display("FAIL bp_stable got %0d exp 11", out_result); else pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_result !== 16'(11 + i))
        $display("FAIL bp_drain%0d got v=%0d r=%0d exp 1/%0d", i, out_valid, out_result, 11 + i); else pass++;
      tick();
    end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_empty got v=%0d rdy=%0d exp 0/1", out_valid, in_ready); else pass++;
    total++; if (op_count !== 16'd9) $display("FAIL bp_op_count got %0d exp 9", op_count); else pass++;
  endtask

  task automatic test_steady();
    logic [15:0] qr[$];
    logic [3:0]  qo[$];
    logic [3:0]  ops[4];
    logic [15:0] er;
    logic [3:0]  eo;
    int errs = 0;
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd8; ops[3] = 4'd9;
    out_ready = 1'b0;
    for (int c = 0; c < 34; c++) begin
      if (c >= 3) out_ready = 1'b1;
      if (c < 23) begin
        in_valid  = 1'b1;
        in_a      = 8'($urandom_range(0, 255));
        in_b      = 8'($urandom_range(1, 255));
        in_opcode = ops[$urandom_range(0, 3)];
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 3 && c < 23 && (out_valid !== 1'b1 || in_ready !== 1'b1)) errs++;
      if (out_valid && out_ready) begin
        if (qr.size() == 0) begin
          errs++;
        end else begin
          er = qr.pop_front();
          eo = qo.pop_front();
          total++; if (out_result !== er || out_opcode !== eo)
            $display("FAIL steady_entry c=%0d got %0d/%0d exp %0d/%0d", c, out_result, out_opcode, er, eo); else pass++;
        end
      end
      if (in_valid && in_ready) begin
        qr.push_back(alu_f(in_a, in_b, in_opcode));
        qo.push_back(in_opcode);
      end
      tick();
    end
    total++; if (errs !== 0) $display("FAIL steady_flow got %0d errors exp 0", errs); else pass++;
    total++; if (qr.size() !== 0 || out_valid !== 1'b0) $display("FAIL steady_left got %0d/%0d exp 0/0", qr.size(), out_valid); else pass++;
    total++; if (op_count !== 16'd32) $display("FAIL steady_op_count got %0d exp 32", op_count); else pass++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; in_opcode = 4'd0;
    for (int i = 0; i < 4; i++) tick();
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL arst_pre got rdy=%0d v=%0d exp 0/1", in_ready, out_valid); else pass++;
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'd0)
      $display("FAIL arst_now got v=%0d rdy=%0d cnt=%0d exp 0/1/0", out_valid, in_ready, op_count); else pass++;
    #1;
    rst = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL arst_ghost got %0d exp 0", out_valid); else pass++;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd3; in_opcode = 4'd0;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 16'd10) $display("FAIL arst_first got v=%0d r=%0d exp 1/10", out_valid, out_result); else pass++;
    tick();
    total++; if (op_count !== 16'd1 || out_valid !== 1'b0) $display("FAIL arst_count got %0d/%0d exp 1/0", op_count, out_valid); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_divide();
    test_backpressure();
    test_steady();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
